// File: rtl/i2c_byte_uart_tx.sv
// Buffered UART transmitter fed by the I2C controller byte strobe; bytes are queued in a FIFO
// and sent LSB-first. Optional even-parity bit is compiled in with `define UART_PARITY_EN.
module i2c_byte_uart_tx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        byte_in,
  input  logic              byte_in_en,
  output logic              byte_ack,
  output logic              uart_tx,
  output logic              busy,
  output logic [ADDR_W:0]   fifo_level,
  output logic              fifo_full,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]    level_q, level_d;
  logic [7:0]         drop_q, drop_d;
  logic               ack_q, ack_d;
  logic [7:0]         mem_q [DEPTH];

  logic pop, wr_en, full, bit_done;

  assign full     = (level_q == (ADDR_W + 1)'(DEPTH));
  assign pop      = (state_q == StIdle) && (level_q != '0);
  // A pop frees a slot on the same edge, so a full FIFO still accepts that cycle.
  assign wr_en    = byte_in_en && (!full || pop);
  assign bit_done = (cnt_q == CNT_W'(DIV - 1));

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (state_q != StIdle) begin
      cnt_d = bit_done ? '0 : cnt_q + 1'b1;
    end
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        if (bit_done) begin
          state_d = StData;
          bit_d   = '0;
        end
      end
      StData: begin
        if (bit_done) begin
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (bit_done) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic; combinational from state so reset forces the line high immediately
  always_comb begin
    uart_tx = 1'b1;
    unique case (state_q)
      StIdle:   uart_tx = 1'b1;
      StStart:  uart_tx = 1'b0;
      StData:   uart_tx = shift_q[bit_q];
`ifdef UART_PARITY_EN
      StParity: uart_tx = ^shift_q;
`endif
      StStop:   uart_tx = 1'b1;
      default:  uart_tx = 1'b1;
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    drop_d   = drop_q;
    ack_d    = wr_en;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !wr_en) begin
      level_d = level_q - 1'b1;
    end
    if (byte_in_en && !wr_en && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
      ack_q    <= ack_d;
    end
  end

  // Storage needs no reset: the level counter alone decides what is valid.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= byte_in;
  end

  assign byte_ack   = ack_q;
  assign busy       = (state_q != StIdle) || (level_q != '0);
  assign fifo_level = level_q;
  assign fifo_full  = full;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_i2c_byte_uart_tx.sv
// Self-checking bench for i2c_byte_uart_tx: directed scenarios plus random strobes,
// compared every cycle against a queue-and-timeline reference model.
module tb_i2c_byte_uart_tx;

  localparam int DIV   = 10;
  localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int F = NB * DIV;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_in_en = 1'b0;
  logic       byte_ack, uart_tx, busy, fifo_full;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;

  i2c_byte_uart_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100),
    .ADDR_W   (2)
  ) u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .byte_in    (byte_in),
    .byte_in_en (byte_in_en),
    .byte_ack   (byte_ack),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .fifo_level (fifo_level),
    .fifo_full  (fifo_full),
    .drop_cnt   (drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: byte queue, drop counter and the edge at which the current frame began.
  logic [7:0] m_q[$];
  int         m_drop;
  bit         m_ack;
  bit         m_fvalid;
  int         m_fstart;
  int         m_next_pop;
  logic [7:0] m_fbyte;
  int         e = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, obs, exp, e);
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_fvalid || e < m_fstart || e >= m_fstart + F) return 1'b1;
    idx = (e - m_fstart) / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_fbyte[idx-1];
`ifdef UART_PARITY_EN
    if (idx == 9) return ^m_fbyte;
`endif
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return (m_fvalid && e >= m_fstart && e < m_fstart + F) || (m_q.size() != 0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_drop     = 0;
    m_ack      = 1'b0;
    m_fvalid   = 1'b0;
    m_next_pop = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tx"},    32'(uart_tx),    32'(exp_tx()));
    check({tag, ".ack"},   32'(byte_ack),   32'(m_ack));
    check({tag, ".busy"},  32'(busy),       32'(exp_busy()));
    check({tag, ".level"}, 32'(fifo_level), 32'(m_q.size()));
    check({tag, ".full"},  32'(fifo_full),  32'(m_q.size() == DEPTH));
    check({tag, ".drop"},  32'(drop_cnt),   32'(m_drop));
  endtask

  task automatic step(input string tag, input bit en, input logic [7:0] d);
    bit pop, acc;
    byte_in_en = en;
    byte_in    = d;
    @(posedge sys_clk);
    e++;
    pop = (e >= m_next_pop) && (m_q.size() != 0);
    acc = en && ((m_q.size() < DEPTH) || pop);
    if (pop) begin
      m_fbyte    = m_q.pop_front();
      m_fstart   = e;
      m_fvalid   = 1'b1;
      m_next_pop = e + F + 1;
    end
    if (acc) m_q.push_back(d);
    else if (en && m_drop < 255) m_drop++;
    m_ack = acc;
    #1;
    byte_in_en = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00);
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    sys_rst_n = 1'b1;

    // Single byte: ack after one edge, line low after the pop edge, busy gone 102 edges on.
    step("a5", 1'b1, 8'hA5);
    idle("a5", F + 10);

    // Six back-to-back strobes: fifth fills the FIFO, sixth is dropped.
    for (int i = 1; i <= 6; i++) step("six", 1'b1, 8'(i));
    check("six.drop1", 32'(drop_cnt), 32'd1);
    idle("six", 5 * (F + 1) + 10);

    // Fill, then strobe continuously across the next pop edge and on to saturation.
    for (int i = 0; i < 5; i++) step("fill", 1'b1, 8'($urandom));
    for (int i = 0; i < F + 10; i++) step("popw", 1'b1, 8'($urandom));
    for (int i = 0; i < 300; i++) step("sat", 1'b1, 8'($urandom));
    check("sat.drop", 32'(drop_cnt), 32'd255);
    idle("drain", 5 * (F + 1) + 10);

    // Reset in the middle of a data bit with bytes still queued.
    for (int i = 0; i < 3; i++) step("pre", 1'b1, 8'($urandom));
    idle("pre", 4 * DIV);
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rstmid");
    @(posedge sys_clk);
    #1;
    check_all("rsthold");
    sys_rst_n = 1'b1;
    idle("post", F + 20);

    // Random traffic with occasional bursts.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int j = 0; j < 6; j++) step("rndb", 1'b1, 8'($urandom));
      end else begin
        step("rnd", ($urandom_range(0, 59) == 0), 8'($urandom));
      end
    end
    idle("end", 5 * (F + 1) + 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
